uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- UART receiver, 8N1 by default. Sits directly downstream of the baud-rate generator and consumes its 16x-oversampling tick. The tick is produced at 50 MHz / 326, giving 9600 baud.
- Synchronizes the asynchronous serial line, detects the start bit, samples each bit at mid-bit, and checks the stop bit.
- Presents the received byte in a holding register with a valid/read handshake, plus framing-error and overrun flags.

Parameters:
- DBIT, 8, number of data bits per frame, LSB first.
- SB_TICK, 16, oversampling ticks spent in the stop bit (16 = 1 stop bit, 32 = 2 stop bits).

Ports:
- clk_50MHz  input  1  system clock, 50 MHz.
- reset  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous serial line; idles high.
- s_tick  input  1  single-cycle oversampling enable, 16 per bit period, from the baud-rate generator.
- rd  input  1  single-cycle read strobe from the consumer; acknowledges the held byte.
- dout  output  DBIT  received data byte, held.
- rx_valid  output  1  dout holds an unread byte.
- frame_err  output  1  last completed frame had rx=0 at the stop-bit sample.
- overrun  output  1  a byte completed while the previous byte was still unread.
- busy  output  1  FSM is not in IDLE.

Behaviour:
- Reset (synchronous, on clk_50MHz edge with reset=1):
  - FSM goes to IDLE; tick counter s and bit counter n = 0; shift register = 0.
  - Synchronizer flops = 1.
  - dout = 0; rx_valid, frame_err, overrun, busy = 0.
  - Reset mid-frame aborts the frame and no byte is delivered.
- Synchronizer: two flip-flops on rx. All FSM decisions use rx_s, the second-stage output, which lags rx by 2 cycles.
- State counters: s is 4 bits in START/DATA and log2(SB_TICK) bits in STOP; n is ceil(log2(DBIT)) bits. The FSM only advances on cycles with s_tick=1, except for the IDLE start detection.
- IDLE:
  - When rx_s=0, go to START with s=0.
  - No tick is required for this transition.
- START:
  - On each s_tick, when s==7 (mid start bit):
    - rx_s=0: go to DATA with s=0, n=0.
    - rx_s=1: false start (glitch); return to IDLE with no flags changed.
  - Otherwise s increments on each s_tick.
- DATA:
  - On each s_tick, when s==15: shift rx_s into the MSB of the shift register (right shift, so LSB is received first) and set s=0.
  - If n==DBIT-1, go to STOP; otherwise n increments.
  - Otherwise s increments.
- STOP:
  - On each s_tick, when s==SB_TICK-1, return to IDLE and complete the frame.
  - Otherwise s increments.
- Frame completion, in the same cycle STOP exits:
  - dout <= shift register.
  - frame_err <= ~rx_s. The byte is delivered even when frame_err=1.
  - If rx_valid=1 and rd=0: overrun <= 1.
  - rx_valid <= 1.
- Read handshake:
  - rd=1 while rx_valid=1 and no completion in the same cycle: rx_valid <= 0 and overrun <= 0.
  - rd and completion in the same cycle: the old byte is consumed, the new byte is loaded, rx_valid stays 1 and overrun is not set.
  - rd while rx_valid=0 is ignored.
- frame_err updates only at frame completion.
- busy = (state != IDLE), registered with the state.
- s_tick asserted on consecutive cycles is legal; each cycle counts as one tick.
- Latency: from the rx falling edge to IDLE exit is 2 cycles. Frame completion occurs 8 + 16·DBIT + SB_TICK ticks after the first START tick (152 ticks for the defaults).

Test Plan:
- Single frame, s_tick pulsed every 4 cycles, rx sends 0xA5 (LSB first) with a valid stop bit -> exactly one completion: dout=0xA5, rx_valid=1, frame_err=0, overrun=0. Then rd pulse -> rx_valid=0 the next cycle.
- Glitch: rx low for 5 ticks, then high -> FSM returns to IDLE; rx_valid, dout and flags unchanged; busy drops.
- Framing error: send 0x3C with rx=0 during the stop sample -> dout=0x3C, rx_valid=1, frame_err=1. The next good frame 0x55 -> frame_err=0.
- Overrun: send 0x11 then 0x22 with no rd -> dout=0x22, overrun=1. A rd pulse -> rx_valid=0 and overrun=0. Also: rd asserted on the exact completion cycle of 0x22 -> overrun stays 0 and rx_valid stays 1.
- Reset mid-frame: assert reset during DATA bit 3 of 0xFF -> all outputs 0 next cycle, FSM in IDLE. A following frame 0x81 is received correctly.
- Back-to-back frames 0x00, 0xFF, 0x7E with 1 stop bit and no idle gap, rd after each completion -> three completions with exact values and no frame_err or overrun.

Source files
------------

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx : 8N1 (by default) UART receiver driven by a 16x oversampling tick.
//
// Ports
//   clk_50MHz  in   system clock
//   reset      in   synchronous, active-high reset
//   rx         in   asynchronous serial line, idles high
//   s_tick     in   one-cycle oversampling enable, 16 per bit period
//   rd         in   one-cycle read strobe, acknowledges the held byte
//   dout       out  received byte (held until the next frame completes)
//   rx_valid   out  dout holds an unread byte
//   frame_err  out  last completed frame saw rx=0 at the stop-bit sample
//   overrun    out  a byte completed while the previous one was unread
//   busy       out  receiver is inside a frame (not IDLE)
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk_50MHz,
    input  logic            reset,
    input  logic            rx,
    input  logic            s_tick,
    input  logic            rd,
    output logic [DBIT-1:0] dout,
    output logic            rx_valid,
    output logic            frame_err,
    output logic            overrun,
    output logic            busy
);

    // The tick counter is shared by all states, so it must be wide enough
    // for the longer of a 16-tick bit and the stop period.
    localparam int SW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
    localparam int NW = ($clog2(DBIT) > 0) ? $clog2(DBIT) : 1;

    localparam logic [SW-1:0] S_MID  = SW'(7);
    localparam logic [SW-1:0] S_LAST = SW'(15);
    localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t          state, state_next;
    logic [SW-1:0]   s, s_next;
    logic [NW-1:0]   n, n_next;
    logic [DBIT-1:0] b, b_next;
    logic            rx_meta, rx_s;
    logic            complete;
    logic [DBIT-1:0] dout_next;
    logic            rx_valid_next, frame_err_next, overrun_next;

    // Two-flop synchronizer; resets to the idle (high) line level so that
    // reset itself never looks like a start bit.
    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // State and holding-register flops. busy is registered from the next
    // state so it tracks the state register exactly.
    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            state     <= IDLE;
            s         <= '0;
            n         <= '0;
            b         <= '0;
            busy      <= 1'b0;
            dout      <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_next;
            s         <= s_next;
            n         <= n_next;
            b         <= b_next;
            busy      <= (state_next != IDLE);
            dout      <= dout_next;
            rx_valid  <= rx_valid_next;
            frame_err <= frame_err_next;
            overrun   <= overrun_next;
        end
    end

    // Next-state logic. Start detection in IDLE needs no tick; everything
    // else only moves on s_tick. The start bit is re-checked at its middle
    // (s==7) and each data bit is sampled 16 ticks later, i.e. mid-bit.
    always_comb begin
        state_next = state;
        s_next     = s;
        n_next     = n;
        b_next     = b;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                    s_next     = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s == S_MID) begin
                        if (!rx_s) begin
                            state_next = DATA;
                            s_next     = '0;
                            n_next     = '0;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        s_next = s + SW'(1);
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s == S_LAST) begin
                        b_next = {rx_s, b[DBIT-1:1]};
                        s_next = '0;
                        if (n == N_LAST) begin
                            state_next = STOP;
                        end else begin
                            n_next = n + NW'(1);
                        end
                    end else begin
                        s_next = s + SW'(1);
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s == S_STOP) begin
                        state_next = IDLE;
                    end else begin
                        s_next = s + SW'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Holding register and flags. A read on the completion cycle consumes
    // the old byte, so the new byte replaces it without flagging overrun.
    always_comb begin
        complete       = (state == STOP) && s_tick && (s == S_STOP);
        dout_next      = dout;
        rx_valid_next  = rx_valid;
        frame_err_next = frame_err;
        overrun_next   = overrun;
        if (complete) begin
            dout_next      = b;
            frame_err_next = ~rx_s;
            rx_valid_next  = 1'b1;
            if (rx_valid && !rd) begin
                overrun_next = 1'b1;
            end
        end else if (rd && rx_valid) begin
            rx_valid_next = 1'b0;
            overrun_next  = 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx : self-checking bench for uart_rx (DBIT=8, SB_TICK=16).
// The bench owns s_tick (one tick every 4 clocks) and drives each serial
// bit for 16 ticks, so every frame is cycle-exact. Expected results are
// queued when a frame is driven; a monitor pops and compares one record
// each time busy falls outside reset.
// ---------------------------------------------------------------------------
module tb_uart_rx;

    logic       clk_50MHz = 1'b0;
    logic       reset     = 1'b1;
    logic       rx        = 1'b1;
    logic       s_tick    = 1'b0;
    logic       rd        = 1'b0;
    logic [7:0] dout;
    logic       rx_valid, frame_err, overrun, busy;

    uart_rx #(.DBIT(8), .SB_TICK(16)) dut (
        .clk_50MHz (clk_50MHz),
        .reset     (reset),
        .rx        (rx),
        .s_tick    (s_tick),
        .rd        (rd),
        .dout      (dout),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #10 clk_50MHz = ~clk_50MHz;

    typedef struct {
        logic [7:0] data;
        bit         stop_ok;
        bit         rd_at_end;
        bit         rd_after;
        int         gap;
        logic [7:0] exp_dout;
        bit         exp_fe;
        bit         exp_ov;
    } frame_vec_t;

    typedef struct {
        bit         valid;
        logic [7:0] dout;
        bit         fe;
        bit         ov;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    bit   prev_busy = 1'b0;
    int   tests_run = 0;
    int   tests_failed = 0;
    int   frame_no = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic cycle();
        @(posedge clk_50MHz);
        #1;
    endtask

    task automatic idleTicks(input int nticks);
        rx = 1'b1;
        for (int i = 0; i < nticks * 4; i++) begin
            s_tick = ((i % 4) == 3);
            cycle();
        end
        s_tick = 1'b0;
    endtask

    // Drives one frame: start bit, data LSB first, stop bit, 16 ticks each.
    // The stop sample lands on stop-bit tick 7; a bad stop is held low only
    // through tick 9 so the line is high again when the receiver re-checks.
    task automatic applyStimulus(input logic [7:0] data, input bit stop_ok,
                                 input bit rd_at_end, input bit rd_after,
                                 input int reset_bit);
        logic [9:0] frame;
        logic       line;
        bit         rd_cycle;
        bit         rst_cycle;
        frame = {1'b1, data, 1'b0};
        for (int bi = 0; bi < 10; bi++) begin
            for (int k = 0; k < 16; k++) begin
                for (int c = 0; c < 4; c++) begin
                    line = frame[bi];
                    if (bi == 9 && !stop_ok && k < 10) line = 1'b0;
                    rd_cycle  = (bi == 9) && ((rd_at_end && k == 7 && c == 3) ||
                                              (rd_after && k == 12 && c == 0));
                    rst_cycle = (bi == reset_bit) && (k == 4) && (c == 0);
                    rx     = line;
                    s_tick = (c == 3);
                    rd     = rd_cycle;
                    reset  = rst_cycle;
                    cycle();
                    if (rd_cycle && !(rd_at_end && k == 7)) begin
                        checkOutput("rx_valid after rd", {31'b0, rx_valid}, 32'd0);
                        checkOutput("overrun after rd", {31'b0, overrun}, 32'd0);
                    end
                    if (rst_cycle) begin
                        checkOutput("dout after mid-frame reset", {24'b0, dout}, 32'd0);
                        checkOutput("rx_valid after mid-frame reset", {31'b0, rx_valid}, 32'd0);
                        checkOutput("frame_err after mid-frame reset", {31'b0, frame_err}, 32'd0);
                        checkOutput("overrun after mid-frame reset", {31'b0, overrun}, 32'd0);
                        checkOutput("busy after mid-frame reset", {31'b0, busy}, 32'd0);
                    end
                end
            end
        end
        rd     = 1'b0;
        reset  = 1'b0;
        s_tick = 1'b0;
        rx     = 1'b1;
    endtask

    // Each fall of busy outside reset is either a completion or a false
    // start; both have a queued expectation of the visible outputs.
    always @(negedge clk_50MHz) begin
        if (reset) begin
            prev_busy = 1'b0;
        end else begin
            if (prev_busy && !busy) begin
                if (sb_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("[TB] FAIL unexpected frame end: dout=0x%0h rx_valid=%0b, no result was expected",
                             dout, rx_valid);
                end else begin
                    mon_e = sb_q.pop_front();
                    frame_no++;
                    checkOutput($sformatf("frame %0d dout", frame_no), {24'b0, dout}, {24'b0, mon_e.dout});
                    checkOutput($sformatf("frame %0d rx_valid", frame_no), {31'b0, rx_valid}, {31'b0, mon_e.valid});
                    checkOutput($sformatf("frame %0d frame_err", frame_no), {31'b0, frame_err}, {31'b0, mon_e.fe});
                    checkOutput($sformatf("frame %0d overrun", frame_no), {31'b0, overrun}, {31'b0, mon_e.ov});
                end
            end
            prev_busy = busy;
        end
    end

    initial begin
        frame_vec_t vecs[10];
        exp_t       e;

        //          data   ok rdE rdA gap  exp    fe ov
        vecs[0] = '{8'hA5, 1, 0,  1,  4,  8'hA5, 0, 0};
        vecs[1] = '{8'h3C, 0, 0,  1,  4,  8'h3C, 1, 0};
        vecs[2] = '{8'h55, 1, 0,  1,  4,  8'h55, 0, 0};
        vecs[3] = '{8'h11, 1, 0,  0,  4,  8'h11, 0, 0};
        vecs[4] = '{8'h22, 1, 0,  1,  4,  8'h22, 0, 1};
        vecs[5] = '{8'h11, 1, 0,  0,  4,  8'h11, 0, 0};
        vecs[6] = '{8'h22, 1, 1,  1,  4,  8'h22, 0, 0};
        vecs[7] = '{8'h00, 1, 0,  1,  0,  8'h00, 0, 0};
        vecs[8] = '{8'hFF, 1, 0,  1,  0,  8'hFF, 0, 0};
        vecs[9] = '{8'h7E, 1, 0,  1,  4,  8'h7E, 0, 0};

        reset = 1'b1;
        repeat (3) cycle();
        checkOutput("reset dout", {24'b0, dout}, 32'd0);
        checkOutput("reset rx_valid", {31'b0, rx_valid}, 32'd0);
        checkOutput("reset frame_err", {31'b0, frame_err}, 32'd0);
        checkOutput("reset overrun", {31'b0, overrun}, 32'd0);
        checkOutput("reset busy", {31'b0, busy}, 32'd0);
        reset = 1'b0;
        idleTicks(4);

        for (int i = 0; i < 10; i++) begin
            e.valid = 1'b1;
            e.dout  = vecs[i].exp_dout;
            e.fe    = vecs[i].exp_fe;
            e.ov    = vecs[i].exp_ov;
            sb_q.push_back(e);
            if (!vecs[i].stop_ok) begin
                // The low stop line restarts the receiver, which then sees a
                // false start; by then the optional read has happened.
                e.valid = !vecs[i].rd_after;
                e.ov    = vecs[i].rd_after ? 1'b0 : vecs[i].exp_ov;
                sb_q.push_back(e);
            end
            applyStimulus(vecs[i].data, vecs[i].stop_ok, vecs[i].rd_at_end,
                          vecs[i].rd_after, -1);
            idleTicks(vecs[i].gap);
        end

        // Glitch: a byte is held, then rx dips for 5 ticks only.
        e = '{1'b1, 8'h5A, 1'b0, 1'b0};
        sb_q.push_back(e);
        applyStimulus(8'h5A, 1'b1, 1'b0, 1'b0, -1);
        idleTicks(4);
        sb_q.push_back(e);
        rx = 1'b0;
        for (int i = 0; i < 20; i++) begin
            s_tick = ((i % 4) == 3);
            cycle();
        end
        idleTicks(8);
        checkOutput("glitch busy", {31'b0, busy}, 32'd0);
        checkOutput("glitch dout held", {24'b0, dout}, 32'h5A);
        checkOutput("glitch rx_valid held", {31'b0, rx_valid}, 32'd1);

        // Reset during data bit 3 of 0xFF: no byte may appear afterwards.
        applyStimulus(8'hFF, 1'b1, 1'b0, 1'b0, 4);
        idleTicks(4);
        checkOutput("no byte after aborted frame", {31'b0, rx_valid}, 32'd0);

        e = '{1'b1, 8'h81, 1'b0, 1'b0};
        sb_q.push_back(e);
        applyStimulus(8'h81, 1'b1, 1'b0, 1'b0, -1);
        idleTicks(4);

        checkOutput("scoreboard drained", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
